counter_nbit: RTL and testbench

Parametrised up/down binary counter, successor to the fixed 4-bit up-counter used in the gate-level netlist flow. Adds configurable width and modulus, direction control, parallel load, wrap or saturate mode, and a sticky overflow flag. Serves as the generic counter primitive for datapath, timer and test-pattern blocks synthesised onto the team's gate and flip-flop library.

---
 rtl/counter_nbit.sv | 83 ++++++++
 tb/tb_counter_nbit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_nbit.sv
// Parametrised up/down counter with modulus, parallel load, wrap/saturate and sticky overflow.
// Optional synchronous clear input i_clr is enabled by defining COUNTER_NBIT_SYNC_CLR_EN.
module counter_nbit #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_sat,
    input  logic             i_ovf_clr,
`ifdef COUNTER_NBIT_SYNC_CLR_EN
    input  logic             i_clr,
`endif
    output logic [WIDTH-1:0] o_counter,
    output logic             o_co,
    output logic             o_ovf
);

    logic [WIDTH-1:0] r_counter;
    logic             r_ovf;
    logic [WIDTH-1:0] w_counter_nxt;
    logic             w_ovf_nxt;
    logic [WIDTH-1:0] w_din_clamped;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_bound_evt;
    logic             w_clr;

`ifdef COUNTER_NBIT_SYNC_CLR_EN
    assign w_clr = i_clr;
`else
    assign w_clr = 1'b0;
`endif

    assign w_at_max      = (r_counter == MAX);
    assign w_at_zero     = (r_counter == '0);
    assign w_din_clamped = (i_din > MAX) ? MAX : i_din;

    // A count edge that crosses the terminal bound in the selected direction.
    assign w_bound_evt = i_en & ~i_ld & ~w_clr & (i_up ? w_at_max : w_at_zero);

    always_comb begin
        w_counter_nxt = r_counter;
        w_ovf_nxt     = r_ovf;
        if (w_clr) begin
            w_counter_nxt = '0;
        end else if (i_ld) begin
            w_counter_nxt = w_din_clamped;
        end else if (i_en) begin
            if (i_up) begin
                if (w_at_max) w_counter_nxt = i_sat ? MAX : '0;
                else          w_counter_nxt = r_counter + WIDTH'(1);
            end else begin
                if (w_at_zero) w_counter_nxt = i_sat ? '0 : MAX;
                else           w_counter_nxt = r_counter - WIDTH'(1);
            end
        end

        // Set beats clear; an explicit sync clear wipes the flag outright.
        if (w_clr)            w_ovf_nxt = 1'b0;
        else if (w_bound_evt) w_ovf_nxt = 1'b1;
        else if (i_ovf_clr)   w_ovf_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counter <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_counter <= w_counter_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign o_counter = r_counter;
    assign o_ovf     = r_ovf;
    assign o_co      = w_bound_evt;

endmodule

// File: tb/tb_counter_nbit.sv
// Scoreboard bench for counter_nbit: two instances (MAX=15, MAX=9) share one stimulus stream.
module tb_counter_nbit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, ld, sat, ovf_clr, clr;
    logic [3:0] din;
    logic [3:0] cnt15, cnt9;
    logic       co15, co9, ovf15, ovf9;

    always #5 clk = ~clk;

    counter_nbit #(.WIDTH(4), .MAX(4'd15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_up(up), .i_ld(ld), .i_din(din),
        .i_sat(sat), .i_ovf_clr(ovf_clr),
`ifdef COUNTER_NBIT_SYNC_CLR_EN
        .i_clr(clr),
`endif
        .o_counter(cnt15), .o_co(co15), .o_ovf(ovf15));

    counter_nbit #(.WIDTH(4), .MAX(4'd9)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_up(up), .i_ld(ld), .i_din(din),
        .i_sat(sat), .i_ovf_clr(ovf_clr),
`ifdef COUNTER_NBIT_SYNC_CLR_EN
        .i_clr(clr),
`endif
        .o_counter(cnt9), .o_co(co9), .o_ovf(ovf9));

`ifdef COUNTER_NBIT_SYNC_CLR_EN
    localparam bit CLR_ON = 1'b1;
`else
    localparam bit CLR_ON = 1'b0;
`endif

    typedef struct {
        int c15;
        int o15;
        int c9;
        int o9;
    } exp_t;

    exp_t q_state[$];
    int   q_co[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_cnt[2];
    int   m_ovf[2];
    int   m_max[2] = '{15, 9};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one edge of a modulo-(MAX+1) counter, written from the behavioural rules.
    task automatic step(input bit r, input bit e, input bit u, input bit l, input int d,
                        input bit s, input bit oc, input bit cl);
        exp_t nx;
        int   co_bits;
        bit   c_eff;
        @(negedge clk);
        rst_n = r; en = e; up = u; ld = l; din = 4'(d); sat = s; ovf_clr = oc; clr = cl;
        c_eff   = cl && CLR_ON;
        co_bits = 0;
        for (int k = 0; k < 2; k++) begin
            int  c, mx, target;
            bit  o, hit;
            if (!r) begin
                m_cnt[k] = 0;
                m_ovf[k] = 0;
            end
            c   = m_cnt[k];
            o   = m_ovf[k] != 0;
            mx  = m_max[k];
            hit = e && !l && !c_eff && (u ? (c == mx) : (c == 0));
            if (hit) co_bits |= (1 << k);
            if (r) begin
                if (c_eff) begin
                    c = 0;
                end else if (l) begin
                    c = (d > mx) ? mx : d;
                end else if (e) begin
                    target = u ? c + 1 : c - 1;
                    if (target > mx)    c = s ? mx : 0;
                    else if (target < 0) c = s ? 0 : mx;
                    else                 c = target;
                end
                if (c_eff)   o = 1'b0;
                else if (hit) o = 1'b1;
                else if (oc)  o = 1'b0;
            end
            m_cnt[k] = c;
            m_ovf[k] = int'(o);
        end
        nx.c15 = m_cnt[0]; nx.o15 = m_ovf[0];
        nx.c9  = m_cnt[1]; nx.o9  = m_ovf[1];
        q_co.push_back(co_bits);
        q_state.push_back(nx);
    endtask

    // Monitor: combinational carry, sampled just after inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (q_co.size() > 0) begin
                int b;
                b = q_co.pop_front();
                chk("co_max15", int'(co15), b & 1);
                chk("co_max9",  int'(co9),  (b >> 1) & 1);
            end
        end
    end

    // Monitor: registered state after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_state.size() > 0) begin
                exp_t x;
                x = q_state.pop_front();
                chk("cnt_max15", int'(cnt15), x.c15);
                chk("ovf_max15", int'(ovf15), x.o15);
                chk("cnt_max9",  int'(cnt9),  x.c9);
                chk("ovf_max9",  int'(ovf9),  x.o9);
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; ld = 1'b0; din = '0;
        sat = 1'b0; ovf_clr = 1'b0; clr = 1'b0;
        m_cnt = '{0, 0};
        m_ovf = '{0, 0};
        #3;
        chk("reset_cnt15", int'(cnt15), 0);
        chk("reset_ovf15", int'(ovf15), 0);
        chk("reset_co15",  int'(co15),  0);
        chk("reset_cnt9",  int'(cnt9),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up-count through the wrap: 1..15, 0, 1 on the MAX=15 instance.
        for (int i = 0; i < 17; i++) step(1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)  step(1, 1, 1, 0, 0, 0, 0, 0);

        // Asynchronous reset between edges with MAX=15 counter at 7.
        @(posedge clk);
        #3;
        chk("pre_reset_cnt15", int'(cnt15), 7);
        rst_n = 1'b0;
        #1;
        chk("async_cnt15", int'(cnt15), 0);
        chk("async_ovf15", int'(ovf15), 0);
        chk("async_cnt9",  int'(cnt9),  0);
        chk("async_ovf9",  int'(ovf9),  0);
        m_cnt = '{0, 0};
        m_ovf = '{0, 0};
        step(0, 0, 1, 0, 0, 0, 0, 0);

        // Down-count from zero: MAX=9 instance reads 9,8,...,0,9.
        for (int i = 0; i < 11; i++) step(1, 1, 0, 0, 0, 0, 0, 0);

        // Saturation at the upper bound, then ovf clear while idle.
        step(1, 0, 1, 1, 14, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 1, 1, 0);

        // Load priority and clamping.
        step(1, 1, 1, 1, 12, 0, 0, 0);
        step(1, 1, 0, 1, 5, 0, 0, 0);

        // Boundary set beats a same-cycle clear.
        step(1, 0, 1, 1, 15, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 1, 0);

        // Sync clear dominates load (no effect when the port is absent).
        step(1, 1, 1, 1, 6, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step(1, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 31) == 0);
        end

        step(1, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("queues_drained", q_state.size() + q_co.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
